// File: rtl/smi_link_frame_receiver_pkg.sv
// Shared definitions for the SMI link frame receiver: status bit positions,
// FSM state encoding and a width helper for parameter-derived counters.
package smi_link_frame_receiver_pkg;

    localparam int unsigned STAT_W       = 4;
    localparam int unsigned STAT_TRUNC   = 0;
    localparam int unsigned STAT_TIMEOUT = 1;
    localparam int unsigned STAT_BADSOF  = 2;
    localparam int unsigned STAT_LINKERR = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int unsigned clog2w(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((64'd1 << w) < 64'(v))) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/smi_keep_to_eofc.sv
// Converts a byte keep mask into a last-flit byte count. A mask that is zero
// or not contiguous from the LSB is flagged and reported as a full flit.
module smi_keep_to_eofc #(
    parameter int unsigned FlitWidth = 8
) (
    input  logic [FlitWidth-1:0] keep,
    output logic [7:0]           eofc,
    output logic                 keep_error
);

    logic [FlitWidth-1:0] keep_inc;
    logic [7:0]           ones;

    // Popcount plus contiguity check: a valid mask has the form 2^k-1, k>=1.
    always_comb begin
        keep_inc   = keep + FlitWidth'(1);
        keep_error = (keep == '0) || ((keep & keep_inc) != '0);
        ones       = 8'd0;
        for (int i = 0; i < FlitWidth; i++) begin
            ones = ones + 8'(keep[i]);
        end
        eofc = keep_error ? 8'(FlitWidth) : ones;
    end

endmodule

// File: rtl/smi_link_frame_receiver.sv
// Link framing stage: registers the raw link word stream once and turns it
// into well-terminated SMI flits with eofc and sticky per-frame status.
// Enforces maximum frame length, inter-flit timeout and SOF/EOF sequencing.
module smi_link_frame_receiver
    import smi_link_frame_receiver_pkg::*;
#(
    parameter int unsigned FlitWidth     = 8,
    parameter int unsigned StatusWidth   = 4,
    parameter int unsigned MaxFrameFlits = 256,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     linkValid,
    input  logic                     linkSof,
    input  logic                     linkEof,
    input  logic [FlitWidth-1:0]     linkKeep,
    input  logic [FlitWidth*8-1:0]   linkData,
    input  logic                     linkError,
    output logic                     dataOutValid,
    output logic [7:0]               dataOutEofc,
    output logic [FlitWidth*8-1:0]   dataOut,
    output logic [StatusWidth-1:0]   dataOutStatus,
    input  logic                     countReset,
    output logic [31:0]              frameCount,
    output logic [31:0]              errorFrameCount
);

    localparam int unsigned DataWidth = FlitWidth * 8;
    localparam int unsigned CountSize = clog2w(MaxFrameFlits);
    localparam int unsigned IdleWidth = clog2w((TimeoutCycles < 2) ? 2 : TimeoutCycles);
    localparam bit          TimeoutEn = (TimeoutCycles != 0);

    localparam logic [CountSize-1:0] CountLast = CountSize'(MaxFrameFlits - 1);
    localparam logic [IdleWidth-1:0] IdleLast  = IdleWidth'(TimeoutEn ? TimeoutCycles - 1 : 0);
    localparam logic [7:0]           EofcFull  = 8'(FlitWidth);

    // Input stage
    logic                 in_valid;
    logic                 in_sof;
    logic                 in_eof;
    logic [FlitWidth-1:0] in_keep;
    logic [DataWidth-1:0] in_data;
    logic                 in_error;

    // Keep decode
    logic [7:0]           keep_eofc;
    logic                 keep_error;

    // FSM state and next-state
    state_t               state, state_d;
    logic [CountSize-1:0] flit_cnt, flit_cnt_d;
    logic [IdleWidth-1:0] idle_cnt, idle_cnt_d;
    logic [STAT_W-1:0]    status_acc, status_acc_d;

    logic                 out_valid_d;
    logic [7:0]           out_eofc_d;
    logic [DataWidth-1:0] out_data_d;
    logic [STAT_W-1:0]    out_status_d;
    logic [STAT_W-1:0]    word_err;
    logic [STAT_W-1:0]    eof_err;
    logic                 eof_emit;

    // Register the link word once; only the valid bit needs a reset value.
    always_ff @(posedge clk) begin
        if (srst) begin
            in_valid <= 1'b0;
        end else begin
            in_valid <= linkValid;
        end
        in_sof   <= linkSof;
        in_eof   <= linkEof;
        in_keep  <= linkKeep;
        in_data  <= linkData;
        in_error <= linkError;
    end

    smi_keep_to_eofc #(
        .FlitWidth (FlitWidth)
    ) u_keep_to_eofc (
        .keep       (in_keep),
        .eofc       (keep_eofc),
        .keep_error (keep_error)
    );

    // Next-state and next-output decode for the framing FSM.
    always_comb begin
        state_d      = state;
        flit_cnt_d   = flit_cnt;
        idle_cnt_d   = idle_cnt;
        status_acc_d = status_acc;
        out_valid_d  = 1'b0;
        out_eofc_d   = 8'd0;
        out_data_d   = in_data;
        out_status_d = '0;

        word_err               = '0;
        word_err[STAT_LINKERR] = in_error;
        eof_err                = '0;
        eof_err[STAT_LINKERR]  = in_error | keep_error;

        case (state)
            ST_ACTIVE: begin
                if (in_valid) begin
                    idle_cnt_d  = '0;
                    out_valid_d = 1'b1;
                    if (in_sof) begin
                        // New frame inside a frame: close the current one, drop the new one.
                        out_data_d                = '0;
                        out_eofc_d                = EofcFull;
                        out_status_d              = status_acc;
                        out_status_d[STAT_BADSOF] = 1'b1;
                        state_d                   = in_eof ? ST_IDLE : ST_DISCARD;
                    end else if (in_eof) begin
                        out_eofc_d   = keep_eofc;
                        out_status_d = status_acc | eof_err;
                        state_d      = ST_IDLE;
                    end else if (flit_cnt == CountLast) begin
                        out_eofc_d               = EofcFull;
                        out_status_d             = status_acc | word_err;
                        out_status_d[STAT_TRUNC] = 1'b1;
                        state_d                  = ST_DISCARD;
                    end else begin
                        flit_cnt_d   = flit_cnt + CountSize'(1);
                        status_acc_d = status_acc | word_err;
                    end
                end else if (TimeoutEn && (idle_cnt == IdleLast)) begin
                    out_valid_d                = 1'b1;
                    out_data_d                 = '0;
                    out_eofc_d                 = EofcFull;
                    out_status_d               = status_acc;
                    out_status_d[STAT_TIMEOUT] = 1'b1;
                    state_d                    = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt + IdleWidth'(1);
                end
            end

            default: begin
                // IDLE and DISCARD both accept a new frame on SOF.
                if (in_valid && in_sof) begin
                    out_valid_d  = 1'b1;
                    idle_cnt_d   = '0;
                    if (in_eof) begin
                        out_eofc_d   = keep_eofc;
                        out_status_d = eof_err;
                        flit_cnt_d   = '0;
                        status_acc_d = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        flit_cnt_d   = CountSize'(1);
                        status_acc_d = word_err;
                        state_d      = ST_ACTIVE;
                    end
                end else if ((state == ST_DISCARD) && in_valid && in_eof) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        eof_emit = out_valid_d && (out_eofc_d != 8'd0);
    end

    // FSM state and registered flit outputs; data is left unreset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state         <= ST_IDLE;
            flit_cnt      <= '0;
            idle_cnt      <= '0;
            status_acc    <= '0;
            dataOutValid  <= 1'b0;
            dataOutEofc   <= 8'd0;
            dataOutStatus <= '0;
        end else begin
            state         <= state_d;
            flit_cnt      <= flit_cnt_d;
            idle_cnt      <= idle_cnt_d;
            status_acc    <= status_acc_d;
            dataOutValid  <= out_valid_d;
            dataOutEofc   <= out_eofc_d;
            dataOutStatus <= StatusWidth'(out_status_d);
        end
        dataOut <= out_data_d;
    end

    // Frame statistics; clearing wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (srst || countReset) begin
            frameCount      <= 32'd0;
            errorFrameCount <= 32'd0;
        end else if (eof_emit) begin
            frameCount <= frameCount + 32'd1;
            if (out_status_d != '0) begin
                errorFrameCount <= errorFrameCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_smi_link_frame_receiver.sv
// Directed bench for smi_link_frame_receiver (FlitWidth=8, MaxFrameFlits=4,
// TimeoutCycles=8). After each drive step the outputs show the flit produced
// from the word driven one step earlier.
module tb_smi_link_frame_receiver;

    logic        clk;
    logic        srst;
    logic        linkValid;
    logic        linkSof;
    logic        linkEof;
    logic [7:0]  linkKeep;
    logic [63:0] linkData;
    logic        linkError;
    logic        dataOutValid;
    logic [7:0]  dataOutEofc;
    logic [63:0] dataOut;
    logic [3:0]  dataOutStatus;
    logic        countReset;
    logic [31:0] frameCount;
    logic [31:0] errorFrameCount;

    int vectors    = 0;
    int miscompares = 0;

    smi_link_frame_receiver #(
        .FlitWidth     (8),
        .StatusWidth   (4),
        .MaxFrameFlits (4),
        .TimeoutCycles (8)
    ) dut (
        .clk             (clk),
        .srst            (srst),
        .linkValid       (linkValid),
        .linkSof         (linkSof),
        .linkEof         (linkEof),
        .linkKeep        (linkKeep),
        .linkData        (linkData),
        .linkError       (linkError),
        .dataOutValid    (dataOutValid),
        .dataOutEofc     (dataOutEofc),
        .dataOut         (dataOut),
        .dataOutStatus   (dataOutStatus),
        .countReset      (countReset),
        .frameCount      (frameCount),
        .errorFrameCount (errorFrameCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [7:0] k, input logic [63:0] d, input logic er);
        linkValid = v;
        linkSof   = s;
        linkEof   = e;
        linkKeep  = k;
        linkData  = d;
        linkError = er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
    endtask

    // Expected flit: v=0 checks only valid; eofc=0 skips status.
    task automatic chk(input string tag, input logic v, input logic [7:0] ec,
                       input logic [63:0] d, input logic [3:0] st);
        vectors++;
        if (!v) begin
            assert (dataOutValid === 1'b0) else begin
                miscompares++;
                $error("FAIL %s: observed valid=%b expected valid=0", tag, dataOutValid);
            end
        end else if (ec == 8'd0) begin
            assert ({dataOutValid, dataOutEofc, dataOut} === {1'b1, 8'd0, d}) else begin
                miscompares++;
                $error("FAIL %s: observed v=%b eofc=%0d data=%h expected v=1 eofc=0 data=%h",
                       tag, dataOutValid, dataOutEofc, dataOut, d);
            end
        end else begin
            assert ({dataOutValid, dataOutEofc, dataOut, dataOutStatus} === {1'b1, ec, d, st}) else begin
                miscompares++;
                $error("FAIL %s: observed v=%b eofc=%0d data=%h st=%h expected v=1 eofc=%0d data=%h st=%h",
                       tag, dataOutValid, dataOutEofc, dataOut, dataOutStatus, ec, d, st);
            end
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] f, input logic [31:0] e);
        vectors++;
        assert ({frameCount, errorFrameCount} === {f, e}) else begin
            miscompares++;
            $error("FAIL %s: observed frames=%0d errframes=%0d expected frames=%0d errframes=%0d",
                   tag, frameCount, errorFrameCount, f, e);
        end
    endtask

    initial begin
        srst       = 1'b1;
        countReset = 1'b0;
        idle();
        idle();

        // Reset state
        vectors++;
        assert ({dataOutValid, dataOutEofc, dataOutStatus} === 13'd0) else begin
            miscompares++;
            $error("FAIL reset_outputs: observed v=%b eofc=%0d st=%h expected all zero",
                   dataOutValid, dataOutEofc, dataOutStatus);
        end
        chk_cnt("reset_counters", 32'd0, 32'd0);
        srst = 1'b0;

        // 1: clean 4-word frame, last keep=0x0F
        drive(1, 1, 0, 8'h00, 64'h1111_1111_1111_1111, 0); chk("t1_pre", 0, 0, 0, 0);
        drive(1, 0, 0, 8'h00, 64'h1212_1212_1212_1212, 0); chk("t1_f0", 1, 0, 64'h1111_1111_1111_1111, 0);
        drive(1, 0, 0, 8'h00, 64'h1313_1313_1313_1313, 0); chk("t1_f1", 1, 0, 64'h1212_1212_1212_1212, 0);
        drive(1, 0, 1, 8'h0F, 64'h0000_0000_1414_1414, 0); chk("t1_f2", 1, 0, 64'h1313_1313_1313_1313, 0);
        idle();                                            chk("t1_eof", 1, 8'd4, 64'h0000_0000_1414_1414, 4'h0);
        idle();                                            chk_cnt("t1_cnt", 32'd1, 32'd0);

        // 2: 6-word frame truncated at 4 flits
        drive(1, 1, 0, 8'h00, 64'h2121_2121_2121_2121, 0); chk("t2_pre", 0, 0, 0, 0);
        drive(1, 0, 0, 8'h00, 64'h2222_2222_2222_2222, 0); chk("t2_f0", 1, 0, 64'h2121_2121_2121_2121, 0);
        drive(1, 0, 0, 8'h00, 64'h2323_2323_2323_2323, 0); chk("t2_f1", 1, 0, 64'h2222_2222_2222_2222, 0);
        drive(1, 0, 0, 8'h00, 64'h2424_2424_2424_2424, 0); chk("t2_f2", 1, 0, 64'h2323_2323_2323_2323, 0);
        drive(1, 0, 0, 8'h00, 64'h2525_2525_2525_2525, 0); chk("t2_trunc", 1, 8'd8, 64'h2424_2424_2424_2424, 4'h1);
        drive(1, 0, 1, 8'hFF, 64'h2626_2626_2626_2626, 0); chk("t2_drop5", 0, 0, 0, 0);
        idle();                                            chk("t2_drop6", 0, 0, 0, 0);
        chk_cnt("t2_cnt", 32'd2, 32'd1);

        // 3: timeout 8 cycles after the last body flit
        drive(1, 1, 0, 8'h00, 64'h3131_3131_3131_3131, 0); chk("t3_pre", 0, 0, 0, 0);
        drive(1, 0, 0, 8'h00, 64'h3232_3232_3232_3232, 0); chk("t3_f0", 1, 0, 64'h3131_3131_3131_3131, 0);
        idle();                                            chk("t3_f1", 1, 0, 64'h3232_3232_3232_3232, 0);
        for (int i = 0; i < 7; i++) begin
            idle();
            chk($sformatf("t3_wait%0d", i), 0, 0, 0, 0);
        end
        idle();                                            chk("t3_term", 1, 8'd8, 64'h0, 4'h2);
        idle();                                            chk("t3_after", 0, 0, 0, 0);

        // 4: SOF inside frame A, frame B dropped, frame C clean
        drive(1, 1, 0, 8'h00, 64'h4141_4141_4141_4141, 0); chk("t4_pre", 0, 0, 0, 0);
        drive(1, 0, 0, 8'h00, 64'h4242_4242_4242_4242, 0); chk("t4_a0", 1, 0, 64'h4141_4141_4141_4141, 0);
        drive(1, 1, 0, 8'h00, 64'h4B4B_4B4B_4B4B_4B4B, 0); chk("t4_a1", 1, 0, 64'h4242_4242_4242_4242, 0);
        drive(1, 0, 0, 8'h00, 64'h4C4C_4C4C_4C4C_4C4C, 0); chk("t4_term", 1, 8'd8, 64'h0, 4'h4);
        drive(1, 0, 1, 8'hFF, 64'h4D4D_4D4D_4D4D_4D4D, 0); chk("t4_b1", 0, 0, 0, 0);
        drive(1, 1, 0, 8'h00, 64'h4E4E_4E4E_4E4E_4E4E, 0); chk("t4_b2", 0, 0, 0, 0);
        drive(1, 0, 1, 8'hFF, 64'h4F4F_4F4F_4F4F_4F4F, 0); chk("t4_c0", 1, 0, 64'h4E4E_4E4E_4E4E_4E4E, 0);
        idle();                                            chk("t4_c1", 1, 8'd8, 64'h4F4F_4F4F_4F4F_4F4F, 4'h0);

        // 5: link error mid-frame, bad keep, zero keep, single-byte frame
        drive(1, 1, 0, 8'h00, 64'h5151_5151_5151_5151, 0); chk("t5_pre", 0, 0, 0, 0);
        drive(1, 0, 0, 8'h00, 64'h5252_5252_5252_5252, 1); chk("t5_e0", 1, 0, 64'h5151_5151_5151_5151, 0);
        drive(1, 0, 1, 8'h03, 64'h0000_0000_0000_5353, 0); chk("t5_e1", 1, 0, 64'h5252_5252_5252_5252, 0);
        idle();                                            chk("t5_e_eof", 1, 8'd2, 64'h0000_0000_0000_5353, 4'h8);
        drive(1, 1, 0, 8'h00, 64'h5454_5454_5454_5454, 0); chk("t5_gap", 0, 0, 0, 0);
        drive(1, 0, 1, 8'h05, 64'h5555_5555_5555_5555, 0); chk("t5_f0", 1, 0, 64'h5454_5454_5454_5454, 0);
        idle();                                            chk("t5_f_eof", 1, 8'd8, 64'h5555_5555_5555_5555, 4'h8);
        drive(1, 1, 1, 8'h00, 64'h5656_5656_5656_5656, 0); chk("t5_gap2", 0, 0, 0, 0);
        drive(1, 1, 1, 8'h01, 64'h0000_0000_0000_0057, 0); chk("t5_zero_keep", 1, 8'd8, 64'h5656_5656_5656_5656, 4'h8);
        idle();                                            chk("t5_single", 1, 8'd1, 64'h0000_0000_0000_0057, 4'h0);
        chk_cnt("t5_cnt", 32'd9, 32'd6);

        // 6: srst mid-frame, then countReset colliding with an EOF
        drive(1, 1, 0, 8'h00, 64'h6161_6161_6161_6161, 0); chk("t6_pre", 0, 0, 0, 0);
        drive(1, 0, 0, 8'h00, 64'h6262_6262_6262_6262, 0); chk("t6_f0", 1, 0, 64'h6161_6161_6161_6161, 0);
        srst = 1'b1;
        idle();
        srst = 1'b0;
        chk("t6_rst_out", 0, 0, 0, 0);
        chk_cnt("t6_rst_cnt", 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk($sformatf("t6_quiet%0d", i), 0, 0, 0, 0);
        end
        drive(1, 1, 1, 8'hFF, 64'h6363_6363_6363_6363, 0); chk("t6_gap", 0, 0, 0, 0);
        drive(1, 1, 1, 8'h00, 64'h6464_6464_6464_6464, 0); chk("t6_h", 1, 8'd8, 64'h6363_6363_6363_6363, 4'h0);
        chk_cnt("t6_cnt1", 32'd1, 32'd0);
        drive(1, 1, 1, 8'hFF, 64'h6565_6565_6565_6565, 0); chk("t6_g", 1, 8'd8, 64'h6464_6464_6464_6464, 4'h8);
        chk_cnt("t6_cnt2", 32'd2, 32'd1);
        countReset = 1'b1;
        idle();
        countReset = 1'b0;
        chk("t6_j", 1, 8'd8, 64'h6565_6565_6565_6565, 4'h0);
        chk_cnt("t6_cnt_clr", 32'd0, 32'd0);
        idle();
        chk_cnt("t6_cnt_hold", 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/smi_link_frame_receiver.md
Name: smi_link_frame_receiver

Overview:
- Framing stage directly upstream of the SMI frame dropper.
- Converts a raw link word stream (sof/eof markers, byte keep mask, link error flag) into SMI flits with eofc and per-frame status.
- Enforces the maximum frame length, inter-flit timeout and SOF/EOF sequencing, so every frame it emits is well-terminated.
- Never applies backpressure and has no stop input; it connects only to non-blocking sinks such as the dropper.

Parameters:
- FlitWidth, 8, flit width in bytes; data is FlitWidth*8 bits.
- StatusWidth, 4, status width; must be >= 4; bits above 3 are driven 0.
- MaxFrameFlits, 256, maximum flits per frame including the EOF flit; legal range 2..65536.
- TimeoutCycles, 1024, idle cycles inside a frame before forced termination; 0 disables the timeout.
- CountSize, derived, width of the flit counter holding MaxFrameFlits-1.

Ports:
- clk  in  1  system clock
- srst  in  1  synchronous active-high reset
- linkValid  in  1  link word valid
- linkSof  in  1  first word of frame
- linkEof  in  1  last word of frame
- linkKeep  in  FlitWidth  byte enables, contiguous from LSB; meaningful only with linkEof
- linkData  in  FlitWidth*8  link word
- linkError  in  1  link-layer error on this word
- dataOutValid  out  1  flit valid
- dataOutEofc  out  8  0 = body flit; 1..FlitWidth = last flit byte count
- dataOut  out  FlitWidth*8  flit data
- dataOutStatus  out  StatusWidth  frame status; meaningful on EOF flit only
- countReset  in  1  clears both statistics counters
- frameCount  out  32  frames emitted
- errorFrameCount  out  32  emitted frames with nonzero status

Behaviour:
- All link inputs are registered once; outputs are registered. Latency is link word at cycle N -> dataOut at N+2.
- Reset values:
  - dataOutValid=0, dataOutEofc=0, dataOutStatus=0, both counters=0, state=IDLE.
  - dataOut is undefined after reset.
  - Reset mid-frame abandons the frame silently; no terminator is emitted.
- Status bits (sticky across the frame, presented on the EOF flit):
  - bit0: truncated.
  - bit1: timeout.
  - bit2: unexpected SOF.
  - bit3: linkError seen on any frame word, or non-contiguous/zero linkKeep on EOF.
- eofc on a normal EOF = popcount(linkKeep). If keep is invalid, eofc=FlitWidth and bit3 is set.
- IDLE state:
  - valid&sof&eof: emit single-flit frame, stay IDLE.
  - valid&sof: emit body flit, flit count=1, go to ACTIVE.
  - valid&~sof: drop the word, stay IDLE.
- ACTIVE state:
  - valid&sof: emit terminator (data 0, eofc=FlitWidth, status bit2 plus accumulated bits). The new frame is discarded: go to DISCARD, or to IDLE if that word also carries eof.
  - valid&eof: emit EOF flit with accumulated status, go to IDLE.
  - valid with flit count == MaxFrameFlits-1 and no eof: emit the word as EOF (eofc=FlitWidth, bit0 set), go to DISCARD.
  - other valid word: emit body flit, flit count +1.
  - idle cycle: the idle counter increments. Any valid word clears it.
  - Timeout: when the idle counter == TimeoutCycles-1 on an idle cycle, emit terminator (data 0, eofc=FlitWidth, bit1 set) on the next output cycle, go to IDLE.
  - Timeout is evaluated only on cycles with no valid word, so it never collides with data.
- DISCARD state:
  - valid&sof: handled exactly as IDLE sof.
  - valid&eof (no sof): go to IDLE.
  - all other words are dropped.
- At most one output flit per cycle in every case. Status accumulator and flit count clear on every frame start.
- Counters:
  - frameCount +1 per emitted EOF flit.
  - errorFrameCount +1 when that flit's status is nonzero.
  - Both wrap at 2^32.
  - countReset has priority over a same-cycle increment.

Decomposition:
- Shared package: status bit index constants (TRUNC=0, TIMEOUT=1, BADSOF=2, LINKERR=3), state encoding (IDLE, ACTIVE, DISCARD), and the clog2-style width helper.
- One natural sub-module, smi_keep_to_eofc: combinational popcount plus contiguity check of linkKeep, returning eofc and a keepError flag.

Test Plan:
1. sof word, 2 body words, eof with keep=0x0F, FlitWidth=8 -> 4 flits at N+2..N+5, last eofc=4, status 0; frameCount=1.
2. MaxFrameFlits=4; 6-word frame -> 4th flit eofc=8, status 0x1; words 5-6 dropped; errorFrameCount=1.
3. TimeoutCycles=8; sof, 1 body word, then idle -> terminator 8 cycles after the last word, eofc=8, data 0, status 0x2.
4. Frame A (sof, body) followed by frame B (sof, body, eof) -> A terminated with status 0x4; B fully dropped; next frame C passes clean.
5. linkError on a mid-frame word, and separately eof with keep=0x05 -> both frames end with status bit3 set; the second has eofc=8.
6. srst asserted mid-frame, then countReset asserted in the same cycle as an EOF -> no terminator after reset; counters read 0.
